// File: rtl/cpu_defs.sv
// Shared CPU-side type definitions.
// Data-bus request bundle, responder FSM states and access sizes.
package cpu_defs;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } resp_state_t;

  function automatic logic [31:0] phys_addr(
    input logic [19:0] tag,
    input logic [7:0]  index,
    input logic [3:0]  offset
  );
    return {tag, index, offset};
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous in-order FIFO of data-bus requests.
// Ports: clk, reset, push/din, pop, full, empty, count, head (current oldest entry).
module req_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  dbus_req_t                  din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output dbus_req_t                  head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dbus_req_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dbus_uncached_responder.sv
// Cache-side responder for the CPU data bus: queues requests and replays
// each one, in order, as a single uncached transaction on an SRAM-like port.
// Ports:
//   CPU side : req, wr, wstrb, size, offset, index, tag, wdata, iscache
//              -> addr_ok, data_ok, rdata
//   Mem side : mem_req, mem_wr, mem_addr, mem_size, mem_wstrb, mem_wdata
//              <- mem_addr_ok, mem_resp_valid, mem_rdata
module dbus_uncached_responder
  import cpu_defs::*;
#(
  parameter int QDEPTH = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [3:0]        wstrb,
  input  logic [2:0]        size,
  input  logic [3:0]        offset,
  input  logic [7:0]        index,
  input  logic [19:0]       tag,
  input  logic [31:0]       wdata,
  input  logic              iscache,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(QDEPTH) + 1;

  resp_state_t     state;
  resp_state_t     state_nx;
  dbus_req_t       din;
  dbus_req_t       head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            pop;
  logic [31:0]     rdata_q;
  logic            unused_iscache;

  assign unused_iscache = iscache;

  assign din = '{
    wr:    wr,
    size:  size,
    wstrb: wstrb,
    addr:  phys_addr(tag, index, offset),
    wdata: wdata
  };

  // Acceptance looks only at the current fill level: a full queue
  // stays closed even in the cycle its head retires.
  assign addr_ok = req && !full && !reset;
  assign pop     = (state == RESP);

  req_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (addr_ok),
    .din   (din),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    data_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nx = SEND;
      end
      SEND: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_nx = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) state_nx = RESP;
      end
      RESP: begin
        data_ok  = 1'b1;
        // The head pops this cycle; continue if anything remains behind it.
        state_nx = (count > CW'(1)) ? SEND : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The head entry stays in place until RESP, so mem_* is stable
  // for the whole SEND phase.
  assign mem_wr    = mem_req & head.wr;
  assign mem_addr  = mem_req ? ADDR_W'(head.addr) : '0;
  assign mem_size  = mem_req ? head.size : '0;
  assign mem_wstrb = mem_req ? head.wstrb : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state == WAIT && mem_resp_valid) begin
      rdata_q <= head.wr ? 32'h0 : mem_rdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_dbus_uncached_responder.sv
// Self-checking bench for dbus_uncached_responder.
// Scoreboard model of queue/order/data plus directed literal checks.
module tb_dbus_uncached_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [2:0]  size = '0;
  logic [3:0]  offset = '0;
  logic [7:0]  index = '0;
  logic [19:0] tag = '0;
  logic [31:0] wdata = '0;
  logic        iscache = 1'b0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  dbus_uncached_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .wr             (wr),
    .wstrb          (wstrb),
    .size           (size),
    .offset         (offset),
    .index          (index),
    .tag            (tag),
    .wdata          (wdata),
    .iscache        (iscache),
    .addr_ok        (addr_ok),
    .data_ok        (data_ok),
    .rdata          (rdata),
    .mem_req        (mem_req),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_size       (mem_size),
    .mem_wstrb      (mem_wstrb),
    .mem_wdata      (mem_wdata),
    .mem_addr_ok    (mem_addr_ok),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  txn_t        iss_q[$];
  logic [31:0] exp_q[$];
  bit          inflight = 0;

  int          acc_cyc[$];
  int          dok_cyc[$];
  logic [31:0] dok_data[$];
  logic        mwr_log[$];
  logic [31:0] maddr_log[$];

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] be_mem  [int unsigned];

  int ack_delay = 0;
  int rsp_delay = 0;
  bit spur = 0;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned w;
    w = int'(a[31:2]);
    return ref_mem.exists(w) ? ref_mem[w] : dflt({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] be_rd(input logic [31:0] a);
    int unsigned w;
    w = int'(a[31:2]);
    return be_mem.exists(w) ? be_mem[w] : dflt({a[31:2], 2'b00});
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ref_mem[int'(a[31:2])] = v;
    be_mem[int'(a[31:2])]  = v;
  endtask

  // Scoreboard: checks every cycle on the falling edge.
  initial begin
    txn_t t;
    logic exp_ok;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (reset) begin
        iss_q.delete();
        exp_q.delete();
        inflight = 0;
      end else begin
        exp_ok = req && (exp_q.size() < 2);
        chk("addr_ok", {71'b0, addr_ok}, {71'b0, exp_ok});
        chk("mem_req_gate",
            {71'b0, mem_req & (inflight | (iss_q.size() == 0))}, 72'b0);
        if (mem_req && iss_q.size() > 0) begin
          t = iss_q[0];
          chk("mem_fields",
              {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
              {t.wr, t.size, t.wstrb, t.addr, t.wdata});
          if (mem_addr_ok) begin
            void'(iss_q.pop_front());
            inflight = 1;
            mwr_log.push_back(mem_wr);
            maddr_log.push_back(mem_addr);
          end
        end
        if (data_ok) begin
          if (exp_q.size() == 0) begin
            chk("spurious_data_ok", {71'b0, data_ok}, 72'b0);
          end else begin
            chk("dok_after_issue", {71'b0, inflight}, 72'd1);
            chk("rdata", {40'b0, rdata}, {40'b0, exp_q.pop_front()});
          end
          inflight = 0;
          dok_cyc.push_back(cyc_n);
          dok_data.push_back(rdata);
        end
        if (exp_ok) begin
          a = {tag, index, offset};
          t = '{wr: wr, size: size, wstrb: wstrb, addr: a, wdata: wdata};
          iss_q.push_back(t);
          if (wr) begin
            ref_mem[int'(a[31:2])] = merge(ref_rd(a), wdata, wstrb);
            exp_q.push_back(32'h0);
          end else begin
            exp_q.push_back(ref_rd(a));
          end
          acc_cyc.push_back(cyc_n);
        end
      end
    end
  end

  // Backend memory: in order, one transaction at a time.
  initial begin
    int ack_cnt;
    int rsp_cnt;
    bit pend;
    logic [31:0] pdata;
    ack_cnt = 0;
    rsp_cnt = 0;
    pend = 0;
    pdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_addr_ok = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata = 32'h5A5A5A5A;
      if (reset) begin
        pend = 0;
        ack_cnt = 0;
        rsp_cnt = 0;
      end else begin
        if (pend) begin
          if (rsp_cnt >= rsp_delay) begin
            mem_resp_valid = 1'b1;
            mem_rdata = pdata;
            pend = 0;
          end else begin
            rsp_cnt++;
          end
        end
        if (mem_req === 1'b1) begin
          if (ack_cnt >= ack_delay) begin
            mem_addr_ok = 1'b1;
            ack_cnt = 0;
            if (mem_wr) begin
              be_mem[int'(mem_addr[31:2])] =
                merge(be_rd(mem_addr), mem_wdata, mem_wstrb);
              pdata = 32'hFFFFFFFF;
            end else begin
              pdata = be_rd(mem_addr);
            end
            pend = 1;
            rsp_cnt = 0;
          end else begin
            ack_cnt++;
            if (spur) begin
              mem_resp_valid = 1'b1;
              mem_rdata = 32'hBADBAD00;
              spur = 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] sz);
    wr = w;
    tag = a[31:12];
    index = a[11:4];
    offset = a[3:0];
    wdata = d;
    wstrb = s;
    size = sz;
    req = 1'b1;
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] sz);
    bit ok;
    ok = 0;
    set_req(w, a, d, s, sz);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = addr_ok;
      tick();
    end
    req = 1'b0;
    if (!ok) chk("send_timeout", {71'b0, ok}, 72'd1);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 300 && (exp_q.size() != 0); i++) tick();
    tick();
    chk(nm, 72'(exp_q.size()), 72'd0);
  endtask

  task automatic wait_dok();
    for (int i = 0; i < 100 && (data_ok !== 1'b1); i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ia;
    int nd;
    int n_ok;
    tick();
    tick();
    @(negedge clk);
    chk("reset_outputs",
        {addr_ok, data_ok, rdata, mem_req, mem_wr, mem_size, mem_wstrb},
        '0);
    chk("reset_mem_bus", {8'b0, mem_addr, mem_wdata}, 72'b0);
    tick();
    reset = 1'b0;
    tick();

    // Single load, minimum latency.
    preload(32'h1FC00014, 32'hDEADBEEF);
    ia = acc_cyc.size();
    nd = dok_cyc.size();
    send(1'b0, 32'h1FC00014, 32'h0, 4'h0, 3'd2);
    drain("t1_drain");
    chk("t1_mem_addr", {40'b0, maddr_log[$]}, {40'b0, 32'h1FC00014});
    chk("t1_rdata", {40'b0, dok_data[$]}, {40'b0, 32'hDEADBEEF});
    chk("t1_dok_count", 72'(dok_cyc.size() - nd), 72'd1);
    chk("t1_latency", 72'(dok_cyc[$] - acc_cyc[ia]), 72'd4);

    // Store then load to the same word.
    nd = dok_cyc.size();
    send(1'b1, 32'h00000100, 32'h12345678, 4'hF, 3'd2);
    send(1'b0, 32'h00000100, 32'h0, 4'h0, 3'd2);
    drain("t2_drain");
    chk("t2_mem_wr_seq", {70'b0, mwr_log[$-1], mwr_log[$]}, 72'b10);
    chk("t2_store_rdata", {40'b0, dok_data[nd]}, 72'h0);
    chk("t2_load_rdata", {40'b0, dok_data[nd+1]}, {40'b0, 32'h12345678});

    // Queue full while the backend refuses the request.
    ack_delay = 1000;
    nd = dok_cyc.size();
    n_ok = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 32'h00000200 + 32'(4 * i), 32'h0, 4'h0, 3'd2);
      @(negedge clk);
      n_ok += int'(addr_ok);
      tick();
    end
    req = 1'b0;
    chk("t3_accepts", 72'(n_ok), 72'd2);
    repeat (3) tick();
    ack_delay = 0;
    drain("t3_drain");
    chk("t3_dok_count", 72'(dok_cyc.size() - nd), 72'd2);

    // Backpressure with a stray response during SEND.
    preload(32'h00000300, 32'hCAFEF00D);
    ack_delay = 5;
    rsp_delay = 7;
    spur = 1;
    ia = acc_cyc.size();
    nd = dok_cyc.size();
    send(1'b0, 32'h00000300, 32'h0, 4'h0, 3'd2);
    drain("t4_drain");
    chk("t4_dok_count", 72'(dok_cyc.size() - nd), 72'd1);
    chk("t4_rdata", {40'b0, dok_data[$]}, {40'b0, 32'hCAFEF00D});
    chk("t4_latency", 72'(dok_cyc[$] - acc_cyc[ia]), 72'd16);
    ack_delay = 0;

    // Reset while waiting on the backend with two entries queued.
    rsp_delay = 100;
    send(1'b0, 32'h00000400, 32'h0, 4'h0, 3'd2);
    send(1'b0, 32'h00000404, 32'h0, 4'h0, 3'd2);
    repeat (4) tick();
    nd = dok_cyc.size();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_outputs",
        {addr_ok, data_ok, rdata, mem_req, mem_wr, mem_size, mem_wstrb},
        '0);
    chk("t5_mem_bus", {8'b0, mem_addr, mem_wdata}, 72'b0);
    rsp_delay = 0;
    repeat (10) tick();
    chk("t5_no_old_dok", 72'(dok_cyc.size() - nd), 72'd0);
    preload(32'h00000500, 32'h0BADC0DE);
    send(1'b0, 32'h00000500, 32'h0, 4'h0, 3'd2);
    drain("t5_drain");
    chk("t5_new_rdata", {40'b0, dok_data[$]}, {40'b0, 32'h0BADC0DE});

    // Accept in the same cycle the only entry retires.
    preload(32'h00000600, 32'h11111111);
    preload(32'h00000604, 32'h22222222);
    preload(32'h00000608, 32'h33333333);
    ia = acc_cyc.size();
    nd = dok_cyc.size();
    send(1'b0, 32'h00000600, 32'h0, 4'h0, 3'd2);
    wait_dok();
    send(1'b0, 32'h00000604, 32'h0, 4'h0, 3'd0);
    wait_dok();
    send(1'b0, 32'h00000608, 32'h0, 4'h0, 3'd1);
    drain("t6_drain");
    chk("t6_overlap_b", 72'(acc_cyc[ia+1]), 72'(dok_cyc[nd]));
    chk("t6_overlap_c", 72'(acc_cyc[ia+2]), 72'(dok_cyc[nd+1]));
    chk("t6_rdata_a", {40'b0, dok_data[nd]}, {40'b0, 32'h11111111});
    chk("t6_rdata_b", {40'b0, dok_data[nd+1]}, {40'b0, 32'h22222222});
    chk("t6_rdata_c", {40'b0, dok_data[nd+2]}, {40'b0, 32'h33333333});

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_uncached_responder.md
Name: dbus_uncached_responder

Overview:
- Responder (cache side) of the CPU_DCache_Interface request/addr_ok/data_ok protocol.
- Accepts CPU data requests, queues them in order and replays each as a single uncached transaction on a simple SRAM-like memory port.
- Returns data_ok and rdata to the CPU strictly in request order.
- Used as the uncached data path, and as a bring-up stand-in for the DCache; the iscache bit is accepted but ignored.

Parameters:
- QDEPTH, 2, pending-request queue entries; power of 2, at least 2.
- ADDR_W, 32, physical address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  CPU request valid
- wr  in  1  1 = store, 0 = load
- wstrb  in  4  store byte enables
- size  in  3  access size: 0 = byte, 1 = half, 2 = word
- offset  in  4  address[3:0]
- index  in  8  address[11:4]
- tag  in  20  physical address[31:12]
- wdata  in  32  store data
- iscache  in  1  ignored
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  response valid, one-cycle pulse
- rdata  out  32  load data; 0 for store responses
- mem_req  out  1  backend request valid
- mem_wr  out  1  backend write
- mem_addr  out  ADDR_W  {tag, index, offset}
- mem_size  out  3  copied from size
- mem_wstrb  out  4  copied from wstrb
- mem_wdata  out  32  copied from wdata
- mem_addr_ok  in  1  backend accepted the request
- mem_resp_valid  in  1  backend response (load data or write ack), in order, one per request
- mem_rdata  in  32  backend load data

Behaviour:
- Reset: all outputs 0; queue empty; FSM in IDLE; any outstanding backend transaction is abandoned. The integrator guarantees the backend is reset in the same cycle.
- Accept: addr_ok = req && (count < QDEPTH). This is combinational, with no dependence on the same-cycle dequeue.
  - On acceptance, {wr, size, wstrb, phys addr, wdata} is written to the queue tail.
  - The tail pointer wraps modulo QDEPTH.
- Queue count:
  - +1 on accept, -1 on RESP exit; simultaneous accept and retire leaves count unchanged.
  - A full queue blocks addr_ok even while an entry is retiring that cycle.
- FSM, serving the queue head:
  - IDLE: if count > 0 go to SEND in the next cycle.
  - SEND: mem_req = 1 and mem_* is driven from the head entry, held stable until mem_addr_ok. On mem_addr_ok go to WAIT.
  - WAIT: mem_req = 0. On mem_resp_valid, latch rdata_q = wr ? 0 : mem_rdata and go to RESP.
  - RESP: data_ok = 1 for exactly one cycle and rdata = rdata_q. Pop the head. Go to SEND if count > 1, else IDLE.
- mem_resp_valid outside WAIT is ignored. mem_addr_ok while mem_req = 0 is ignored.
- Minimum latency with mem_addr_ok and mem_resp_valid both asserted immediately:
  - accept in cycle T;
  - SEND (mem_req) in T+2;
  - WAIT in T+3 (mem_resp_valid sampled);
  - data_ok in T+4.
- Back-to-back: the next request's SEND immediately follows the previous RESP. At most one backend transaction is in flight.
- rdata is held at its last value when data_ok = 0. Only the value while data_ok = 1 is meaningful.
- Loads and stores share one ordering. A load after a store to the same address observes the store because the backend is strictly in order.
- No cancellation: every accepted request produces exactly one data_ok.

Decomposition:
- Shared package cpu_defs (existing), additions:
  - dbus_req_t struct {wr, size[2:0], wstrb[3:0], addr[31:0], wdata[31:0]};
  - enum resp_state_t {IDLE, SEND, WAIT, RESP};
  - constants SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2.
- One sub-module: req_fifo, a parameterised synchronous FIFO of dbus_req_t with push, pop, full, empty, count and head outputs.
- The FSM and response register stay in the top module.

Test Plan:
- Single load: req, wr = 0, tag = 20'h1FC00, index = 8'h01, offset = 4'h4; backend returns 32'hDEADBEEF.
  - Required: mem_addr = 32'h1FC00014, addr_ok = 1 in the request cycle, exactly one data_ok with rdata = 32'hDEADBEEF.
- Store then load to the same address 32'h00000100: store wdata = 32'h12345678, wstrb = 4'hF.
  - Required: two mem transactions, with mem_wr = 1 then 0; data_ok twice in order; store rdata = 0; load rdata equals the backend's value.
- Queue full: hold req for 4 cycles while mem_addr_ok = 0.
  - Required: addr_ok in exactly 2 cycles, then 0; mem_req and mem_addr stable throughout; after mem_addr_ok is released, all 2 responses arrive.
- Backpressure: mem_addr_ok delayed 5 cycles and mem_resp_valid delayed 7 cycles.
  - Required: mem_* held stable; a spurious mem_resp_valid pulse in SEND is ignored; a single data_ok follows the WAIT-state response.
- Reset mid-operation: reset asserted in WAIT with 2 entries queued.
  - Required: next cycle all outputs are 0 and the queue is empty; no data_ok is produced for the old entries; a new request then completes normally.
- Simultaneous accept and retire at count = 1.
  - Required: count stays 1, then drains to 0; 3 back-to-back loads return rdata in issue order.
